ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_ram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Two-port round-robin arbiter in front of a single-port RAM with
// combinational read data. Each port issues one word read or write at a
// time; the arbiter registers the winning request and drives the RAM only
// from those registers, so the RAM sees a stable address and data for the
// whole transaction.
//
// Handshake: a port raises req together with we/addr/wdata and holds all of
// them stable until it sees its one-cycle ack. rdata and err are valid only
// while ack is high. In the cycle after ack the port either drops req or
// presents a new request, which is granted in that same (IDLE) cycle.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request
//   a_ack/a_err/a_rdata        port A response
//   b_*                        port B, same as port A
//   ram_load, ram_write        RAM read enable / write strobe
//   ram_addr, ram_wdata        RAM address / write data
//   ram_rdata                  RAM combinational read data
//   busy                       high whenever the FSM is not in IDLE
module ram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int WR_HOLD   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic              a_err,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic              b_err,
    output logic [DATA_W-1:0] b_rdata,
    output logic              ram_load,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WR   = 3'd2,
        ERR  = 3'd3,
        ACK  = 3'd4
    } state_t;

    // Last WR cycle index; the counter runs 0 .. WR_HOLD-1.
    localparam logic [3:0]      WR_LAST   = 4'(WR_HOLD - 1);
    // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state;
    state_t            state_nx;

    logic              sel_b_q;   // granted port of the current transaction (1 = B)
    logic              last_b_q;  // port granted by the previous completed transaction
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;
    logic [3:0]        wr_cnt_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    logic              grant_any;
    logic              grant_b;
    logic              g_we;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_wdata;
    logic              g_oob;

    // Grant selection: a lone request wins; on a tie the port that was not
    // granted last wins.
    always_comb begin
        grant_any = a_req | b_req;
        grant_b   = b_req & (~a_req | ~last_b_q);
        g_we      = grant_b ? b_we    : a_we;
        g_addr    = grant_b ? b_addr  : a_addr;
        g_wdata   = grant_b ? b_wdata : a_wdata;
        g_oob     = {1'b0, g_addr} >= DEPTH_LIM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    if (g_oob) begin
                        state_nx = ERR;
                    end else if (g_we) begin
                        state_nx = WR;
                    end else begin
                        state_nx = RD;
                    end
                end
            end
            RD:  state_nx = ACK;
            WR:  if (wr_cnt_q == WR_LAST) state_nx = ACK;
            ERR: state_nx = ACK;
            ACK: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_b_q   <= 1'b0;
            last_b_q  <= 1'b1;   // so port A wins the first tie
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            wr_cnt_q  <= 4'd0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_any) begin
                        sel_b_q  <= grant_b;
                        we_q     <= g_we;
                        addr_q   <= g_addr;
                        wdata_q  <= g_wdata;
                        err_q    <= 1'b0;
                        wr_cnt_q <= 4'd0;
                    end
                end
                RD: begin
                    if (sel_b_q) begin
                        b_rdata_q <= ram_rdata;
                    end else begin
                        a_rdata_q <= ram_rdata;
                    end
                end
                WR: begin
                    wr_cnt_q <= wr_cnt_q + 4'd1;
                end
                ERR: begin
                    err_q <= 1'b1;
                    if (sel_b_q) begin
                        b_rdata_q <= '0;
                    end else begin
                        a_rdata_q <= '0;
                    end
                end
                ACK: begin
                    last_b_q <= sel_b_q;
                end
                default: ;
            endcase
        end
    end

    // RAM side is driven purely from the registered request.
    assign ram_load  = (state == RD) & ~we_q;
    assign ram_write = (state == WR) & we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;

    assign a_ack   = (state == ACK) & ~sel_b_q;
    assign b_ack   = (state == ACK) & sel_b_q;
    assign a_err   = a_ack & err_q;
    assign b_err   = b_ack & err_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter. u_dut uses WR_HOLD=1, u_dut3 uses
// WR_HOLD=3 for the reset-abort scenario. Each has a small RAM model.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst3_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    int          cyc_cnt = 0;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
    logic        a_ack, a_err, b_ack, b_err, ram_load, ram_write, busy;
    logic [31:0] a_rdata, b_rdata, ram_addr, ram_wdata, ram_rdata;

    logic        c_a_req = 0, c_a_we = 0;
    logic [31:0] c_a_addr = 0, c_a_wdata = 0;
    logic        c_b_req = 0, c_b_we = 0;
    logic [31:0] c_b_addr = 0, c_b_wdata = 0;
    logic        c_a_ack, c_a_err, c_b_ack, c_b_err, c_ram_load, c_ram_write, c_busy;
    logic [31:0] c_a_rdata, c_b_rdata, c_ram_addr, c_ram_wdata, c_ram_rdata;

    logic [31:0] mem  [0:255];
    logic [31:0] mem3 [0:255];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge clk) if (ram_write)   mem[ram_addr[7:0]]    <= ram_wdata;
    always @(posedge clk) if (c_ram_write) mem3[c_ram_addr[7:0]] <= c_ram_wdata;
    assign ram_rdata   = mem[ram_addr[7:0]];
    assign c_ram_rdata = mem3[c_ram_addr[7:0]];

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .WR_HOLD(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
        .ram_load(ram_load), .ram_write(ram_write), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_DEPTH(256), .WR_HOLD(3)) u_dut3 (
        .clk(clk), .rst_n(rst3_n),
        .a_req(c_a_req), .a_we(c_a_we), .a_addr(c_a_addr), .a_wdata(c_a_wdata),
        .a_ack(c_a_ack), .a_err(c_a_err), .a_rdata(c_a_rdata),
        .b_req(c_b_req), .b_we(c_b_we), .b_addr(c_b_addr), .b_wdata(c_b_wdata),
        .b_ack(c_b_ack), .b_err(c_b_err), .b_rdata(c_b_rdata),
        .ram_load(c_ram_load), .ram_write(c_ram_write), .ram_addr(c_ram_addr),
        .ram_wdata(c_ram_wdata), .ram_rdata(c_ram_rdata), .busy(c_busy)
    );

    // Driver: presents one request on u_dut and observes it to completion.
    // Req is left high; the caller drops it or presents the next request.
    task automatic do_txn(input bit port_b, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int ld,
                          output int wr, output logic err, output logic [31:0] rd,
                          output bit other, output bit addr_bad, output int ack_cyc);
        bit done;
        lat = -1; ld = 0; wr = 0; err = 0; rd = '0; other = 0; addr_bad = 0;
        ack_cyc = -1; done = 0;
        @(posedge clk); #1;
        if (port_b) begin
            b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata;
        end else begin
            a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata;
        end
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (ram_load)  ld++;
            if (ram_write) wr++;
            if ((ram_load || ram_write) && ram_addr !== addr) addr_bad = 1;
            if (port_b ? a_ack : b_ack) other = 1;
            if (port_b ? b_ack : a_ack) begin
                lat = c; done = 1; ack_cyc = cyc_cnt;
                err = port_b ? b_err : a_err;
                rd  = port_b ? b_rdata : a_rdata;
            end
        end
    endtask

    task automatic idle_ports();
        @(posedge clk); #1;
        a_req = 0; b_req = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; rst3_n = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({a_ack, a_err, b_ack, b_err, ram_load, ram_write, busy} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {a_ack, a_err, b_ack, b_err, ram_load, ram_write, busy});
        end
        checks++;
        if ({ram_addr, ram_wdata, a_rdata, b_rdata} !== 128'b0) begin
            failures++;
            $display("FAIL reset_data addr=%h wdata=%h a_rd=%h b_rd=%h want=0",
                     ram_addr, ram_wdata, a_rdata, b_rdata);
        end
        rst_n = 1; rst3_n = 1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_write_a();
        int lat, ld, wr, ac; logic err; logic [31:0] rd; bit oth, abad;
        do_txn(0, 1, 32'd5, 32'hDEADBEEF, lat, ld, wr, err, rd, oth, abad, ac);
        idle_ports();
        checks++;
        if (lat !== 2 || wr !== 1 || ld !== 0) begin
            failures++;
            $display("FAIL write_a lat=%0d wr=%0d ld=%0d want lat=2 wr=1 ld=0", lat, wr, ld);
        end
        checks++;
        if (err !== 1'b0 || oth || abad) begin
            failures++;
            $display("FAIL write_a_flags err=%b other_ack=%0d addr_bad=%0d want 0 0 0", err, oth, abad);
        end
    endtask

    task automatic test_read_b();
        int lat, ld, wr, ac; logic err; logic [31:0] rd; bit oth, abad;
        do_txn(1, 0, 32'd5, 32'h0, lat, ld, wr, err, rd, oth, abad, ac);
        idle_ports();
        checks++;
        if (lat !== 2 || ld !== 1 || wr !== 0 || oth || abad) begin
            failures++;
            $display("FAIL read_b lat=%0d ld=%0d wr=%0d other=%0d abad=%0d want 2 1 0 0 0",
                     lat, ld, wr, oth, abad);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || err !== 1'b0) begin
            failures++;
            $display("FAIL read_b_data got=%h err=%b want=deadbeef err=0", rd, err);
        end
        // second write from B, used as round-robin read data later
        do_txn(1, 1, 32'd6, 32'hCAFEF00D, lat, ld, wr, err, rd, oth, abad, ac);
        idle_ports();
        checks++;
        if (lat !== 2 || wr !== 1) begin
            failures++;
            $display("FAIL write_b lat=%0d wr=%0d want lat=2 wr=1", lat, wr);
        end
    endtask

    task automatic test_round_robin();
        bit          exp_b [6] = '{0, 1, 0, 1, 0, 1};
        bit          got_b;
        bit          seen;
        logic [31:0] exp_d;
        logic [31:0] got_d;
        @(posedge clk); #1;
        a_req = 1; a_we = 0; a_addr = 32'd5;
        b_req = 1; b_we = 0; b_addr = 32'd6;
        for (int n = 0; n < 6; n++) begin
            seen = 0; got_b = 0; got_d = '0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (a_ack || b_ack) begin
                    seen = 1;
                    checks++;
                    if (a_ack && b_ack) begin
                        failures++;
                        $display("FAIL rr_both_ack n=%0d a_ack=1 b_ack=1 want one", n);
                    end
                    got_b = b_ack;
                    got_d = b_ack ? b_rdata : a_rdata;
                end
            end
            exp_d = exp_b[n] ? 32'hCAFEF00D : 32'hDEADBEEF;
            checks++;
            if (!seen || got_b !== exp_b[n] || got_d !== exp_d) begin
                failures++;
                $display("FAIL rr_grant n=%0d seen=%0d port_b=%0d data=%h want port_b=%0d data=%h",
                         n, seen, got_b, got_d, exp_b[n], exp_d);
            end
        end
        idle_ports();
    endtask

    task automatic test_error();
        int lat, ld, wr, ac; logic err; logic [31:0] rd; bit oth, abad;
        do_txn(0, 0, 32'd256, 32'h0, lat, ld, wr, err, rd, oth, abad, ac);
        idle_ports();
        checks++;
        if (lat !== 2 || ld !== 0 || wr !== 0 || err !== 1'b1) begin
            failures++;
            $display("FAIL error_txn lat=%0d ld=%0d wr=%0d err=%b want 2 0 0 1", lat, ld, wr, err);
        end
        checks++;
        if (rd !== 32'h0 || oth) begin
            failures++;
            $display("FAIL error_rdata got=%h other=%0d want=0 other=0", rd, oth);
        end
        checks++;
        if (b_rdata !== 32'hCAFEF00D || b_ack !== 1'b0) begin
            failures++;
            $display("FAIL rdata_hold b_rdata=%h b_ack=%b want cafef00d 0", b_rdata, b_ack);
        end
    endtask

    task automatic test_back_to_back();
        int lat, ld, wr, ac; logic err; logic [31:0] rd; bit oth, abad;
        logic [31:0] vals [3] = '{32'h11111111, 32'h22222222, 32'h33333333};
        int prev_ac;
        for (int i = 0; i < 3; i++) begin
            do_txn(0, 1, 32'(i + 1), vals[i], lat, ld, wr, err, rd, oth, abad, ac);
            idle_ports();
        end
        prev_ac = -1;
        for (int i = 0; i < 3; i++) begin
            do_txn(0, 0, 32'(i + 1), 32'h0, lat, ld, wr, err, rd, oth, abad, ac);
            checks++;
            if (lat !== 2 || rd !== vals[i] || err !== 1'b0) begin
                failures++;
                $display("FAIL b2b_read i=%0d lat=%0d data=%h err=%b want lat=2 data=%h err=0",
                         i, lat, rd, err, vals[i]);
            end
            if (prev_ac >= 0) begin
                checks++;
                if (ac - prev_ac !== 3) begin
                    failures++;
                    $display("FAIL b2b_spacing i=%0d gap=%0d want=3", i, ac - prev_ac);
                end
            end
            prev_ac = ac;
        end
        idle_ports();
    endtask

    task automatic test_reset_abort();
        bit ack_seen;
        bit done;
        int lat, wr;
        @(posedge clk); #1;
        c_a_req = 1; c_a_we = 1; c_a_addr = 32'd7; c_a_wdata = 32'h00001234;
        @(negedge clk);                 // IDLE, grant at next edge
        @(negedge clk);                 // first WR cycle
        checks++;
        if (c_ram_write !== 1'b1 || c_ram_addr !== 32'd7) begin
            failures++;
            $display("FAIL abort_wr_start write=%b addr=%h want 1 7", c_ram_write, c_ram_addr);
        end
        @(negedge clk);                 // second WR cycle
        #2 rst3_n = 0;
        #1;
        checks++;
        if (c_ram_write !== 1'b0 || c_busy !== 1'b0 || c_a_ack !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset write=%b busy=%b ack=%b want 0 0 0",
                     c_ram_write, c_busy, c_a_ack);
        end
        c_a_req = 0;
        @(negedge clk);
        rst3_n = 1;
        ack_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (c_a_ack || c_busy) ack_seen = 1;
        end
        checks++;
        if (ack_seen) begin
            failures++;
            $display("FAIL abort_no_ack got ack/busy after release want none");
        end
        // retry completes normally: ack at cycle 1+WR_HOLD = 4
        @(posedge clk); #1;
        c_a_req = 1;
        lat = -1; wr = 0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (c_ram_write) wr++;
            if (c_a_ack) begin
                lat = c; done = 1;
            end
        end
        @(posedge clk); #1;
        c_a_req = 0;
        checks++;
        if (lat !== 4 || wr !== 3 || mem3[7] !== 32'h00001234) begin
            failures++;
            $display("FAIL abort_retry lat=%0d wr=%0d mem=%h want lat=4 wr=3 mem=00001234",
                     lat, wr, mem3[7]);
        end
    endtask

    initial begin
        test_reset();
        test_write_a();
        test_read_b();
        test_round_robin();
        test_error();
        test_back_to_back();
        test_reset_abort();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
